servo_ramp_sequencer: RTL and testbench
=======================================

Name: servo_ramp_sequencer

Overview:
Command-driven controller for the cube-turning servo PWM generators. It accepts one move command at a time (channel, target pulse width in clk cycles) and ramps that channel's duty value toward the target by a fixed step once per servo frame. It then holds for a settle interval and reports completion. Its outputs drive the d/t/enable inputs of per-channel PWM generators; it sits between the LM32 Wishbone register slave and the PWM bank.

Parameters:
NCH, 4, number of servo channels (≥1)
PERIOD, 2000000, frame length in clk cycles (20 ms at 100 MHz); also driven onto t_o
DMIN, 50000, minimum legal pulse width (0.5 ms)
DMAX, 250000, maximum legal pulse width (2.5 ms)
STEP, 1000, maximum duty change per frame (≥1)
SETTLE, 25, frames to hold after target is reached (0 allowed)

Ports:
clk  in  1  system clock
res  in  1  synchronous active-high reset
cmd_valid  in  1  move command present
cmd_ready  out  1  controller can accept a command
cmd_ch  in  CW=max(1,$clog2(NCH))  target channel index
cmd_target  in  32  requested pulse width, clk cycles
duty_o  out  NCH*32  per-channel current pulse width; channel i at [32i+31:32i]
t_o  out  32  constant PERIOD for the PWM generators
en_o  out  NCH  per-channel PWM enable
frame_o  out  1  one-cycle strobe at each frame start
busy  out  1  move in progress (state ≠ IDLE)
done  out  1  one-cycle pulse when a move completes

Behaviour:
- Reset: frame counter = 0; state = IDLE; every duty = (DMIN+DMAX)/2; en_o = 0; done = 0; settle counter = 0. The reset values of cmd_ready and busy follow from IDLE: cmd_ready = 1, busy = 0.
- Frame timer: fcnt counts 0..PERIOD-1, then wraps to 0. frame_o = (fcnt==0), so it is high in the first cycle after res deasserts.
- Handshake: cmd_ready = (state==IDLE). A transfer occurs when cmd_valid && cmd_ready. The controller captures cmd_ch and the clamped target (target < DMIN → DMIN; target > DMAX → DMAX; compare unsigned 32-bit).
- On accept with cmd_ch < NCH: en_o[cmd_ch] is set and stays set until reset; state → RAMP the next cycle.
- On accept with cmd_ch ≥ NCH: the command is dropped, en_o and duties are unchanged, done pulses the next cycle, state stays IDLE.
- RAMP: actions happen only in frame_o cycles.
  - If |target − duty| ≤ STEP: duty := target and state → SETTLE.
  - Otherwise: duty moves by ±STEP toward target.
  - A target equal to the current duty still spends one frame in RAMP.
  - The duty update is visible on duty_o in the cycle after frame_o.
- Accept coinciding with frame_o: the first step happens at the next frame, not the current one.
- SETTLE: on entry, the settle counter is loaded with SETTLE.
  - Each frame_o decrements the counter.
  - When the counter is 0 (immediately on entry if SETTLE=0), done pulses for one cycle and state → IDLE.
  - done and the cmd_ready reassertion occur in the same cycle.
- Duty values change only for the commanded channel. Other channels hold their values.
- Reset mid-move: all state returns to reset values at the next edge. No done pulse is produced.

Optional Feature:
Macro SERVO_ABORT_EN.
- Defined: adds input abort (1 bit). With abort high in RAMP or SETTLE, the controller returns to IDLE at the next edge. The channel's duty is frozen at its current value, done is not pulsed, and en_o is unchanged. abort in IDLE has no effect.
- Not defined: no abort port. Moves always run to completion.

Decomposition:
- Package servo_pkg holds:
  - state enum {IDLE, RAMP, SETTLE}
  - default PERIOD/DMIN/DMAX/STEP/SETTLE constants
  - function clamp_duty (clamp to [DMIN,DMAX])
  - function step_toward (one ramp step)
- One sub-module, servo_frame_timer: PERIOD counter producing frame_o.

Test Plan:
All scenarios use PERIOD=100, DMIN=50, DMAX=250, STEP=10, SETTLE=2, NCH=4.
- Reset → duty_o all 150, en_o=0000, cmd_ready=1, busy=0; frame_o pulses every 100 cycles starting in the first cycle after reset.
- cmd ch0 target 200 → en_o[0]=1; duty0 steps 160,170,180,190,200 on five consecutive frames; done pulses exactly 2 frames after duty0 reaches 200; other channels stay 150.
- cmd ch1 target 300, then ch1 target 10 → duty1 ramps to 250 (clamped), then down to 50 (clamped); final step of 145→ target 145 from 150 completes in one frame (separate cmd ch2 target 145).
- Second cmd asserted while busy → cmd_ready=0 and cmd_valid held with the payload unchanged; accepted in the done cycle; its ramp starts at the following frame.
- res pulsed mid-ramp on ch3 (duty3=180) → next cycle duty3=150, en_o=0, state IDLE, no done.
- SERVO_ABORT_EN defined: abort during ch0 ramp at duty0=170 → IDLE next edge, duty0 stays 170, no done, en_o[0]=1.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: shared state type, default timing constants and duty arithmetic helpers
package servo_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_SETTLE} state_t;
  localparam int PERIOD_DEF = 2000000;
  localparam int DMIN_DEF = 50000;
  localparam int DMAX_DEF = 250000;
  localparam int STEP_DEF = 1000;
  localparam int SETTLE_DEF = 25;
  function automatic logic [31:0] clamp_duty(input logic [31:0] v, input logic [31:0] lo, input logic [31:0] hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
  function automatic logic [31:0] step_toward(input logic [31:0] d, input logic [31:0] t, input logic [31:0] s);
    return t > d ? (t - d <= s ? t : d + s) : (d - t <= s ? t : d - s);
  endfunction
endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: free-running frame counter, frame_o high while the count is zero
module servo_frame_timer #(
  parameter int PERIOD = 2000000
) (
  input  logic clk,
  input  logic res,
  output logic frame_o
);
  logic [31:0] fcnt_q, fcnt_d;
  assign fcnt_d = fcnt_q == 32'(PERIOD - 1) ? '0 : fcnt_q + 32'd1;
  assign frame_o = fcnt_q == '0;
  always_ff @(posedge clk) begin
    if (res) fcnt_q <= '0;
    else fcnt_q <= fcnt_d;
  end
endmodule

// File: rtl/servo_ramp_sequencer.sv
// servo_ramp_sequencer: one-move-at-a-time servo duty ramp controller; SERVO_ABORT_EN adds an abort input
module servo_ramp_sequencer
  import servo_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PERIOD = PERIOD_DEF,
  parameter int DMIN = DMIN_DEF,
  parameter int DMAX = DMAX_DEF,
  parameter int STEP = STEP_DEF,
  parameter int SETTLE = SETTLE_DEF,
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              res,
`ifdef SERVO_ABORT_EN
  input  logic              abort,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CW-1:0]     cmd_ch,
  input  logic [31:0]       cmd_target,
  output logic [NCH*32-1:0] duty_o,
  output logic [31:0]       t_o,
  output logic [NCH-1:0]    en_o,
  output logic              frame_o,
  output logic              busy,
  output logic              done
);
  localparam logic [31:0] MID = 32'((DMIN + DMAX) / 2);
  state_t state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [31:0] tgt_q, tgt_d, cnt_q, cnt_d, nxt;
  logic [NCH-1:0] en_q, en_d;
  logic [31:0] duty_q [NCH];
  logic [31:0] duty_d [NCH];
  logic done_q, done_d, frame, ab;
`ifdef SERVO_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif
  servo_frame_timer #(.PERIOD(PERIOD)) u_timer (.clk(clk), .res(res), .frame_o(frame));
  assign frame_o = frame;
  assign cmd_ready = state_q == S_IDLE;
  assign busy = !cmd_ready;
  assign done = done_q;
  assign en_o = en_q;
  assign t_o = 32'(PERIOD);
  assign nxt = step_toward(duty_q[ch_q], tgt_q, 32'(STEP));
  for (genvar i = 0; i < NCH; i++) begin : g_duty
    assign duty_o[32*i +: 32] = duty_q[i];
  end
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    en_d = en_q;
    duty_d = duty_q;
    done_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (cmd_valid && 32'(cmd_ch) < NCH) begin
        en_d[cmd_ch] = 1'b1;
        ch_d = cmd_ch;
        tgt_d = clamp_duty(cmd_target, 32'(DMIN), 32'(DMAX));
        state_d = S_RAMP;
      end else if (cmd_valid) begin
        done_d = 1'b1;
      end
    end else if (ab) begin
      state_d = S_IDLE;
    end else if (state_q == S_RAMP) begin
      if (frame) begin
        duty_d[ch_q] = nxt;
        state_d = nxt == tgt_q ? S_SETTLE : S_RAMP;
        cnt_d = 32'(SETTLE);
      end
    end else if (cnt_q == '0) begin
      done_d = 1'b1;
      state_d = S_IDLE;
    end else if (frame) begin
      cnt_d = cnt_q - 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_IDLE;
      ch_q <= '0;
      tgt_q <= MID;
      cnt_q <= '0;
      en_q <= '0;
      duty_q <= '{default: MID};
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      duty_q <= duty_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// tb_servo_ramp_sequencer: directed checks of reset, ramping, clamping, handshake hold and mid-move reset
module tb_servo_ramp_sequencer;
  localparam int NCH = 4;
  logic clk = 1'b0, res = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_ch = '0;
  logic [31:0] cmd_target = '0;
  logic cmd_ready, frame_o, busy, done;
  logic [NCH*32-1:0] duty_o;
  logic [31:0] t_o;
  logic [NCH-1:0] en_o;
`ifdef SERVO_ABORT_EN
  logic abort = 1'b0;
`endif
  int total = 0, bad = 0;
  int fr, cyc, early, cnt;
  always #5 clk = ~clk;
  servo_ramp_sequencer #(.NCH(NCH), .PERIOD(100), .DMIN(50), .DMAX(250), .STEP(10), .SETTLE(2)) dut (
    .clk(clk), .res(res),
`ifdef SERVO_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_target(cmd_target),
    .duty_o(duty_o), .t_o(t_o), .en_o(en_o), .frame_o(frame_o), .busy(busy), .done(done)
  );
  function automatic logic [31:0] duty(input int c);
    return duty_o[32*c +: 32];
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_o && n < 300);
    chk("frame_seen", 64'(frame_o), 1);
  endtask
  task automatic step_chk(input int c, input logic [31:0] e, input string tag);
    int n;
    wait_frame(n);
    @(negedge clk);
    chk(tag, duty(c), e);
  endtask
  task automatic wait_done(output int frames);
    int n = 0;
    frames = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
      if (frame_o && !done) frames++;
    end
    chk("done_seen", 64'(done), 1);
  endtask
  task automatic send(input logic [1:0] ch, input logic [31:0] tgt);
    cmd_ch = ch;
    cmd_target = tgt;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    chk("rst_frame", 64'(frame_o), 1);
    chk("rst_duty", 64'(duty_o), {4{32'd150}});
    chk("rst_en", 64'(en_o), 0);
    chk("rst_ready", 64'(cmd_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("t_o", 64'(t_o), 100);
    wait_frame(cyc);
    chk("frame_period", 64'(cyc), 100);
    send(2'd0, 32'd200);
    @(negedge clk);
    chk("a_nostep_on_accept_frame", duty(0), 150);
    chk("a_en", 64'(en_o), 4'b0001);
    chk("a_busy", 64'(busy), 1);
    for (int k = 1; k <= 5; k++) step_chk(0, 32'(150 + 10 * k), "a_step");
    chk("a_others", 64'(duty_o[127:32]), {3{32'd150}});
    wait_done(fr);
    chk("a_settle_frames", 64'(fr), 2);
    chk("a_done_ready", 64'(cmd_ready), 1);
    chk("a_done_busy", 64'(busy), 0);
    send(2'd1, 32'd300);
    @(negedge clk);
    chk("a_done_pulse", 64'(done), 0);
    for (int k = 1; k <= 10; k++) step_chk(1, 32'(150 + 10 * k), "b_up");
    wait_done(fr);
    send(2'd1, 32'd10);
    for (int k = 1; k <= 20; k++) step_chk(1, 32'(250 - 10 * k), "b_down");
    wait_done(fr);
    chk("b_final", duty(1), 50);
    send(2'd2, 32'd145);
    step_chk(2, 32'd145, "b_small_step");
    chk("b_small_busy", 64'(busy), 1);
    wait_done(fr);
    chk("b_small_settle", 64'(fr), 2);
    chk("b_duties", 64'(duty(0)), 200);
    chk("b_d3", 64'(duty(3)), 150);
    chk("b_en", 64'(en_o), 4'b0111);
    send(2'd2, 32'd165);
    cmd_ch = 2'd0;
    cmd_target = 32'd190;
    cmd_valid = 1'b1;
    early = 0;
    cnt = 0;
    while (!done && cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (!done && cmd_ready) early++;
    end
    chk("c_ready_low_while_busy", 64'(early), 0);
    chk("c_done", 64'(done), 1);
    chk("c_ready_in_done", 64'(cmd_ready), 1);
    chk("c_d2", duty(2), 165);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("c_accepted", 64'(busy), 1);
    chk("c_hold_before_frame", duty(0), 200);
    step_chk(0, 32'd190, "c_step");
    wait_done(fr);
    send(2'd3, 32'd250);
    for (int k = 1; k <= 3; k++) step_chk(3, 32'(150 + 10 * k), "d_step");
    chk("d_en_before", 64'(en_o), 4'b1111);
    res = 1'b1;
    @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    chk("d_duty3", duty(3), 150);
    chk("d_duty0", duty(0), 150);
    chk("d_en", 64'(en_o), 0);
    chk("d_ready", 64'(cmd_ready), 1);
    chk("d_busy", 64'(busy), 0);
    chk("d_frame", 64'(frame_o), 1);
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("d_no_done", 64'(cnt), 0);
`ifdef SERVO_ABORT_EN
    send(2'd0, 32'd200);
    step_chk(0, 32'd160, "e_step");
    step_chk(0, 32'd170, "e_step");
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("e_busy", 64'(busy), 0);
    chk("e_ready", 64'(cmd_ready), 1);
    chk("e_done", 64'(done), 0);
    chk("e_en", 64'(en_o), 4'b0001);
    cnt = 0;
    for (int k = 0; k < 250; k++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("e_no_done", 64'(cnt), 0);
    chk("e_frozen", duty(0), 170);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
